// File: rtl/sram_fifo_pkg.sv
// sram_fifo_pkg: shared sizing helpers for the SRAM-backed FIFO.
//   addr_width(size)  - pointer width for a power-of-two entry count
//   count_width(size) - occupancy counter width, able to hold 0..size
package sram_fifo_pkg;

  function automatic int addr_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  function automatic int count_width(input int size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/sram_fifo_sram_1r1w.sv
// sram_1r1w: block SRAM model with one write port and one read port.
//   clk        - rising-edge clock for both ports
//   write_en   - write write_data to write_addr at this edge
//   write_addr - write address
//   write_data - write data
//   read_en    - capture the addressed word into read_data at this edge
//   read_addr  - read address
//   read_data  - registered read data, valid one cycle after the address
// READ_DURING_WRITE = "NEW_DATA" forwards the word being written when both
// ports hit the same address in one cycle; any other value returns the old
// contents. The array is never reset.
module sram_1r1w
  import sram_fifo_pkg::*;
#(
  parameter int    DATA_WIDTH        = 64,
  parameter int    SIZE              = 64,
  parameter string READ_DURING_WRITE = "NEW_DATA"
) (
  input  logic                        clk,
  input  logic                        write_en,
  input  logic [addr_width(SIZE)-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0]       write_data,
  input  logic                        read_en,
  input  logic [addr_width(SIZE)-1:0] read_addr,
  output logic [DATA_WIDTH-1:0]       read_data
);

  localparam bit NEW_DATA = (READ_DURING_WRITE == "NEW_DATA");

  logic [DATA_WIDTH-1:0] mem [SIZE];
  logic                  collide;

  assign collide = NEW_DATA && write_en && (write_addr == read_addr);

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[write_addr] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (read_en) begin
      read_data <= collide ? write_data : mem[read_addr];
    end
  end

endmodule

// File: rtl/sram_fifo.sv
// sram_fifo: show-ahead FIFO around a single 1R1W block SRAM.
//   clk            - sole clock, rising edge
//   reset          - asynchronous active-low reset
//   flush_en       - discard all entries at the next edge (overrides enq/deq)
//   full           - registered, count == SIZE
//   almost_full    - registered, count >= ALMOST_FULL_THRESHOLD
//   enqueue_en     - write enqueue_value at the tail this cycle
//   enqueue_value  - data to write
//   empty          - registered, no valid head entry
//   almost_empty   - registered, count <= ALMOST_EMPTY_THRESHOLD
//   dequeue_en     - pop the head this cycle
//   dequeue_value  - head entry, valid whenever empty == 0
// Optional macro SRAM_FIFO_CHECK_EN compiles in simulation-only checks for
// overflow, underflow and count/pointer consistency.
module sram_fifo
  import sram_fifo_pkg::*;
#(
  parameter int WIDTH                  = 64,
  parameter int SIZE                   = 64,
  parameter int ALMOST_FULL_THRESHOLD  = SIZE,
  parameter int ALMOST_EMPTY_THRESHOLD = 1,
  parameter int ADDR_WIDTH             = addr_width(SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_en,
  output logic             full,
  output logic             almost_full,
  input  logic             enqueue_en,
  input  logic [WIDTH-1:0] enqueue_value,
  output logic             empty,
  output logic             almost_empty,
  input  logic             dequeue_en,
  output logic [WIDTH-1:0] dequeue_value
);

  localparam int CNT_W = count_width(SIZE);

  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(SIZE);
  localparam logic [CNT_W-1:0]      AF_THR   = CNT_W'(ALMOST_FULL_THRESHOLD);
  localparam logic [CNT_W-1:0]      AE_THR   = CNT_W'(ALMOST_EMPTY_THRESHOLD);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] head_ptr, head_ptr_next;
  logic [ADDR_WIDTH-1:0] tail_ptr, tail_ptr_next;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [CNT_W-1:0]      count, count_next;
  logic                  do_enq, do_deq;
  logic                  full_q, almost_full_q, empty_q, almost_empty_q;

  // Flush wins over both operations, so the SRAM never sees a flush-cycle write.
  assign do_enq = enqueue_en & ~flush_en;
  assign do_deq = dequeue_en & ~flush_en;

  // Look one entry ahead on a pop so the successor lands on dequeue_value
  // right after the edge; the SRAM's new-data forwarding covers the case
  // where that entry is being written in the same cycle.
  assign read_addr = dequeue_en ? (head_ptr + PTR_ONE) : head_ptr;

  always_comb begin
    head_ptr_next = head_ptr;
    tail_ptr_next = tail_ptr;
    count_next    = count;
    if (flush_en) begin
      head_ptr_next = '0;
      tail_ptr_next = '0;
      count_next    = '0;
    end else begin
      if (do_enq) tail_ptr_next = tail_ptr + PTR_ONE;
      if (do_deq) head_ptr_next = head_ptr + PTR_ONE;
      case ({do_enq, do_deq})
        2'b10:   count_next = count + CNT_ONE;
        2'b01:   count_next = count - CNT_ONE;
        default: count_next = count;
      endcase
    end
  end

  // Flags are derived from count_next so they change on the same edge as count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_ptr       <= '0;
      tail_ptr       <= '0;
      count          <= '0;
      full_q         <= 1'b0;
      almost_full_q  <= 1'b0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
    end else begin
      head_ptr       <= head_ptr_next;
      tail_ptr       <= tail_ptr_next;
      count          <= count_next;
      full_q         <= (count_next == CNT_FULL);
      almost_full_q  <= (count_next >= AF_THR);
      empty_q        <= (count_next == '0);
      almost_empty_q <= (count_next <= AE_THR);
    end
  end

  assign full         = full_q;
  assign almost_full  = almost_full_q;
  assign empty        = empty_q;
  assign almost_empty = almost_empty_q;

  sram_1r1w #(
    .DATA_WIDTH       (WIDTH),
    .SIZE             (SIZE),
    .READ_DURING_WRITE("NEW_DATA")
  ) u_sram (
    .clk       (clk),
    .write_en  (do_enq),
    .write_addr(tail_ptr),
    .write_data(enqueue_value),
    .read_en   (1'b1),
    .read_addr (read_addr),
    .read_data (dequeue_value)
  );

`ifdef SRAM_FIFO_CHECK_EN
  always @(posedge clk) begin
    if (reset) begin
      if (!flush_en && enqueue_en && full_q && !dequeue_en)
        $error("sram_fifo: enqueue while full");
      if (!flush_en && dequeue_en && empty_q)
        $error("sram_fifo: dequeue while empty");
      // Equal pointers mean either empty or full; full settles which.
      if (full_q ? ((count != CNT_FULL) || (tail_ptr != head_ptr))
                 : (count != CNT_W'(ADDR_WIDTH'(tail_ptr - head_ptr))))
        $error("sram_fifo: count %0d inconsistent with pointers", count);
    end
  end
`else
  // Checks compiled out; behaviour is identical.
`endif

endmodule
